// File: rtl/morse_key_timer.sv
// Morse key front end: synchronizes and debounces the raw key, times each press
// as dot or dash, and flags letter boundaries and overflowing letters.
module morse_key_timer #(
    parameter int DEBOUNCE_CYC   = 500000,
    parameter int DOT_MAX_CYC    = 15000000,
    parameter int LETTER_GAP_CYC = 35000000,
    parameter int MAX_SYMS       = 5
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iEnable,
    input  logic       iKEY_N,
    output logic       oPressed,
    output logic       oSymValid,
    output logic       oSymDash,
    output logic       oLetterEnd,
    output logic       oAbort,
    output logic [2:0] oSymCount
);

    localparam int CNT_W = $clog2(LETTER_GAP_CYC + 1);
    localparam int DEB_W = $clog2(DEBOUNCE_CYC + 1);

    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] DOT_MAX   = CNT_W'(DOT_MAX_CYC);
    localparam logic [CNT_W-1:0] PRESS_SAT = CNT_W'(DOT_MAX_CYC + 1);
    localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(LETTER_GAP_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [2:0]       SYM_MAX   = 3'(MAX_SYMS);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PRESS    = 2'd1;
    localparam logic [1:0] ST_GAP      = 2'd2;
    localparam logic [1:0] ST_WAIT_REL = 2'd3;

    logic [1:0]       sync_q;
    logic             key_s;
    logic             deb_q, deb_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             en_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
    logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [2:0]       sym_cnt_q, sym_cnt_d;
    logic             pressed_q;
    logic             sym_valid_q, sym_valid_d;
    logic             sym_dash_q, sym_dash_d;
    logic             letter_end_q, letter_end_d;
    logic             abort_q, abort_d;

    // Synchronizer idles at the released (high) level of the active-low key
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], iKEY_N};
        end
    end

    assign key_s = ~sync_q[1];

    // Debouncer: level flips only after DEBOUNCE_CYC consecutive disagreeing cycles
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (key_s != deb_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_d     = ~deb_q;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end else begin
            deb_cnt_d = '0;
        end
    end

    // Symbol/letter sequencer; the terminal gap count beats a simultaneous new press
    always_comb begin
        state_d      = state_q;
        press_cnt_d  = press_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        sym_cnt_d    = sym_cnt_q;
        sym_valid_d  = 1'b0;
        sym_dash_d   = 1'b0;
        letter_end_d = 1'b0;
        abort_d      = 1'b0;
        if (!iEnable) begin
            state_d     = ST_IDLE;
            press_cnt_d = '0;
            gap_cnt_d   = '0;
            sym_cnt_d   = 3'd0;
        end else if (!en_q) begin
            state_d     = deb_q ? ST_WAIT_REL : ST_IDLE;
            press_cnt_d = '0;
            gap_cnt_d   = '0;
            sym_cnt_d   = 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (deb_q) begin
                        state_d     = ST_PRESS;
                        press_cnt_d = CNT_ONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PRESS: begin
                    if (deb_q) begin
                        if (press_cnt_q != PRESS_SAT) begin
                            press_cnt_d = press_cnt_q + 1'b1;
                        end else begin
                            press_cnt_d = press_cnt_q;
                        end
                    end else if (sym_cnt_q < SYM_MAX) begin
                        sym_valid_d = 1'b1;
                        sym_dash_d  = (press_cnt_q > DOT_MAX);
                        sym_cnt_d   = sym_cnt_q + 3'd1;
                        gap_cnt_d   = '0;
                        press_cnt_d = '0;
                        state_d     = ST_GAP;
                    end else begin
                        abort_d     = 1'b1;
                        sym_cnt_d   = 3'd0;
                        press_cnt_d = '0;
                        state_d     = ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == GAP_END) begin
                        letter_end_d = 1'b1;
                        sym_cnt_d    = 3'd0;
                        gap_cnt_d    = '0;
                        if (deb_q) begin
                            state_d     = ST_PRESS;
                            press_cnt_d = CNT_ONE;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (deb_q) begin
                        state_d     = ST_PRESS;
                        press_cnt_d = CNT_ONE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
                ST_WAIT_REL: begin
                    if (!deb_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_REL;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    press_cnt_d = '0;
                    gap_cnt_d   = '0;
                    sym_cnt_d   = 3'd0;
                end
            endcase
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            deb_q        <= 1'b0;
            deb_cnt_q    <= '0;
            en_q         <= 1'b0;
            state_q      <= ST_IDLE;
            press_cnt_q  <= '0;
            gap_cnt_q    <= '0;
            sym_cnt_q    <= 3'd0;
            pressed_q    <= 1'b0;
            sym_valid_q  <= 1'b0;
            sym_dash_q   <= 1'b0;
            letter_end_q <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            deb_q        <= deb_d;
            deb_cnt_q    <= deb_cnt_d;
            en_q         <= iEnable;
            state_q      <= state_d;
            press_cnt_q  <= press_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            sym_cnt_q    <= sym_cnt_d;
            pressed_q    <= deb_d & iEnable;
            sym_valid_q  <= sym_valid_d;
            sym_dash_q   <= sym_dash_d;
            letter_end_q <= letter_end_d;
            abort_q      <= abort_d;
        end
    end

    assign oPressed   = pressed_q;
    assign oSymValid  = sym_valid_q;
    assign oSymDash   = sym_dash_q;
    assign oLetterEnd = letter_end_q;
    assign oAbort     = abort_q;
    assign oSymCount  = sym_cnt_q;

endmodule

// File: tb/tb_morse_key_timer.sv
// Scoreboard bench for morse_key_timer: stimulus pushes expected strobe events,
// a negedge monitor pops and compares them whenever a strobe appears.
module tb_morse_key_timer;

    localparam int K_SYM = 0;
    localparam int K_LE  = 1;
    localparam int K_AB  = 2;

    typedef struct {
        int   kind;
        logic dash;
        int   cnt;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       key_n;
    logic       pressed;
    logic       sym_valid;
    logic       sym_dash;
    logic       letter_end;
    logic       abort_s;
    logic [2:0] sym_count;

    int  checks   = 0;
    int  failures = 0;
    ev_t exp_q[$];

    morse_key_timer #(
        .DEBOUNCE_CYC  (4),
        .DOT_MAX_CYC   (20),
        .LETTER_GAP_CYC(50),
        .MAX_SYMS      (5)
    ) dut (
        .iCLK      (clk),
        .iRST_N    (rst_n),
        .iEnable   (en),
        .iKEY_N    (key_n),
        .oPressed  (pressed),
        .oSymValid (sym_valid),
        .oSymDash  (sym_dash),
        .oLetterEnd(letter_end),
        .oAbort    (abort_s),
        .oSymCount (sym_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int kind, input logic dash, input int cnt);
        ev_t e;
        e.kind = kind;
        e.dash = dash;
        e.cnt  = cnt;
        exp_q.push_back(e);
    endtask

    task automatic press(input int n);
        key_n = 1'b0;
        tick(n);
        key_n = 1'b1;
    endtask

    // Monitor: every strobe must match the oldest expected event
    always @(negedge clk) begin
        if (rst_n && (sym_valid || letter_end || abort_s)) begin
            int  kind_a;
            ev_t e;
            kind_a = sym_valid ? K_SYM : (letter_end ? K_LE : K_AB);
            chk("strobe_mutex", int'(sym_valid) + int'(letter_end) + int'(abort_s), 1);
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe_kind", kind_a, -1);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind", kind_a, e.kind);
                chk("sym_count", int'(sym_count), e.cnt);
                if (e.kind == K_SYM) begin
                    chk("sym_dash", int'(sym_dash), int'(e.dash));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        key_n = 1'b1;
        tick(3);
        chk("rst_pressed", int'(pressed), 0);
        chk("rst_symvalid", int'(sym_valid), 0);
        chk("rst_letterend", int'(letter_end), 0);
        chk("rst_abort", int'(abort_s), 0);
        chk("rst_symcount", int'(sym_count), 0);
        rst_n = 1'b1;
        tick(5);

        // Glitch shorter than the debounce window
        key_n = 1'b0;
        tick(3);
        key_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("glitch_pressed", int'(pressed), 0);
            tick(1);
        end
        tick(20);

        // Dot then letter end
        push(K_SYM, 1'b0, 1);
        push(K_LE, 1'b0, 0);
        key_n = 1'b0;
        tick(8);
        chk("dot_pressed", int'(pressed), 1);
        tick(2);
        key_n = 1'b1;
        tick(80);

        // Dot/dash boundary within one letter
        push(K_SYM, 1'b0, 1);
        push(K_SYM, 1'b1, 2);
        push(K_LE, 1'b0, 0);
        press(20);
        tick(10);
        press(21);
        tick(80);

        // Overflow: sixth symbol aborts the letter
        for (int i = 1; i <= 5; i++) push(K_SYM, 1'b0, i);
        push(K_AB, 1'b0, 0);
        for (int i = 0; i < 6; i++) begin
            press(10);
            tick(10);
        end
        tick(80);
        chk("abort_symcount", int'(sym_count), 0);

        // Enable raised while key held: release gives no strobe
        en    = 1'b0;
        key_n = 1'b0;
        tick(20);
        chk("disabled_pressed", int'(pressed), 0);
        en = 1'b1;
        tick(3);
        chk("enabled_pressed", int'(pressed), 1);
        tick(5);
        key_n = 1'b1;
        tick(80);
        push(K_SYM, 1'b0, 1);
        push(K_LE, 1'b0, 0);
        press(10);
        tick(80);

        // Reset mid-press drops the letter and the press
        push(K_SYM, 1'b0, 1);
        press(10);
        tick(10);
        key_n = 1'b0;
        tick(15);
        chk("premid_symcount", int'(sym_count), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_pressed", int'(pressed), 0);
        chk("midrst_symcount", int'(sym_count), 0);
        chk("midrst_strobes", int'(sym_valid) + int'(letter_end) + int'(abort_s), 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        key_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("postrst_pressed", int'(pressed), 0);
            tick(1);
        end
        tick(80);

        chk("pending_events", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/morse_key_timer.md
Name: morse_key_timer

Overview:
- Front end of the RX receive path: conditions the raw Morse key and classifies each press as dot or dash by its held duration.
- Detects the inter-letter silence and marks the end of each letter.
- Emits one-cycle symbol and letter-end strobes for the RX letter decoder, plus a debounced key level for buzzer gating.

Parameters:
- DEBOUNCE_CYC, 500000: consecutive stable synchronized cycles required before the debounced level changes (10 ms at 50 MHz).
- DOT_MAX_CYC, 15000000: press length in cycles at or below which a press is a dot; longer presses are dashes (300 ms).
- LETTER_GAP_CYC, 35000000: release length in cycles that ends a letter (700 ms).
- MAX_SYMS, 5: maximum symbols per letter.

Ports:
- iCLK, input, 1: system clock, 50 MHz.
- iRST_N, input, 1: asynchronous active-low reset.
- iEnable, input, 1: block enabled (RX mode).
- iKEY_N, input, 1: raw key, active-low, asynchronous to iCLK.
- oPressed, output, 1: debounced key level; 1 = pressed.
- oSymValid, output, 1: one-cycle strobe; a symbol was completed.
- oSymDash, output, 1: 1 = dash, 0 = dot; meaningful only while oSymValid = 1.
- oLetterEnd, output, 1: one-cycle strobe; the current letter is complete.
- oAbort, output, 1: one-cycle strobe; a letter exceeded MAX_SYMS and was discarded.
- oSymCount, output, 3: number of symbols accepted in the current letter.

Behaviour:
- Reset (iRST_N = 0, asynchronous):
  - All outputs are 0.
  - Synchronizer flops and debounced level take the released state (1 on the active-low side).
  - All counters are 0; FSM enters IDLE.
- Input conditioning:
  - iKEY_N passes through a 2-flop synchronizer and is inverted to active-high.
  - The debounce counter resets whenever the synchronized level equals the debounced level.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYC, the debounced level flips that cycle and the counter clears.
  - oPressed is the registered debounced level. It is gated to 0 while iEnable = 0; the debouncer itself runs regardless of iEnable.
- Counters:
  - press_cnt and gap_cnt are sized to clog2(LETTER_GAP_CYC + 1).
  - press_cnt saturates at DOT_MAX_CYC + 1.
  - sym_cnt is 3 bits and is driven onto oSymCount.
- FSM states: IDLE, PRESS, GAP, WAIT_REL.
  - IDLE:
    - Debounced rise → PRESS, with press_cnt = 1.
  - PRESS:
    - press_cnt increments each cycle while pressed.
    - On debounced fall, if sym_cnt < MAX_SYMS: next cycle oSymValid = 1 and oSymDash = (press_cnt > DOT_MAX_CYC); sym_cnt increments; gap_cnt = 0; state → GAP.
    - On debounced fall, if sym_cnt = MAX_SYMS: next cycle oAbort = 1 and no oSymValid; sym_cnt = 0; state → IDLE.
  - GAP:
    - gap_cnt increments each released cycle.
    - When gap_cnt reaches LETTER_GAP_CYC: next cycle oLetterEnd = 1; sym_cnt = 0; state → IDLE.
    - Debounced rise before that point → PRESS, with press_cnt = 1 and sym_cnt kept.
    - If the debounced rise and the terminal gap count occur in the same cycle, oLetterEnd wins: oLetterEnd fires, sym_cnt clears, and the press is still timed as the first symbol of the next letter.
  - WAIT_REL:
    - Entered when iEnable rises while the debounced level is pressed.
    - No strobes are emitted. Debounced fall → IDLE.
- iEnable = 0, synchronous:
  - FSM is held in IDLE; press_cnt, gap_cnt and sym_cnt are cleared.
  - All strobes are 0; a pending letter is dropped without oLetterEnd.
  - On the first enabled cycle: if pressed → WAIT_REL, else IDLE.
- Mutual exclusion: at most one of oSymValid, oLetterEnd and oAbort is high in any cycle.
- Latency: debounced edge to strobe is 1 cycle. Raw edge to strobe is 2 (sync) + DEBOUNCE_CYC + 1 cycles.

Test Plan:
Bench parameters for all scenarios: DEBOUNCE_CYC = 4, DOT_MAX_CYC = 20, LETTER_GAP_CYC = 50, iEnable = 1.
1. Raw glitch: iKEY_N low for 3 cycles → oPressed stays 0; no strobe ever.
2. Dot then letter end:
   - Press held 10 cycles, then released → exactly one oSymValid with oSymDash = 0; oSymCount = 1.
   - 50 released cycles after the debounced fall → one oLetterEnd; oSymCount returns to 0.
3. Dash boundary:
   - Press of 20 debounced cycles → dot.
   - Press of 21 debounced cycles → dash.
   - Both presses within one letter → oSymCount = 2 and no oLetterEnd between them.
4. Overflow:
   - Six dots, with 10 gap cycles between them → five oSymValid strobes.
   - On release of the sixth → oAbort = 1 and oSymCount = 0; no oLetterEnd follows.
5. Enable and reset:
   - iEnable raised while the key is held → no strobe on its release.
   - Separately, iRST_N pulsed low mid-press → all outputs 0 immediately; the subsequent release produces no symbol.
